// File: rtl/pgm_gfx_ddr_bridge.sv
// PGM graphics-ROM fetch to MiSTer DDR3 Avalon read bridge.
// Define PGM_GFX_CACHE_EN for a one-line, four-word line-fill cache.
module pgm_gfx_ddr_bridge #(
    parameter logic [28:0] BASE_ADDR  = 29'h0300_0000,
    parameter int          LINE_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic [28:0] req_addr,
    output logic [63:0] req_dout,
    output logic        req_busy,
    output logic        req_valid,
    input  logic        inval,
    output logic [28:0] DDRAM_ADDR,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic        DDRAM_RD,
    input  logic        DDRAM_BUSY,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY
);

    typedef enum logic [2:0] {IDLE, HIT, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic        hit;
    logic [28:0] aligned;

`ifdef PGM_GFX_CACHE_EN
    localparam logic [7:0] BURST = 8'(LINE_WORDS);

    logic [63:0] line [LINE_WORDS];
    logic [28:0] addr_q;
    logic [26:0] tag;
    logic        tag_valid;
    logic        fill_kill;
    logic [1:0]  beat;

    assign hit     = tag_valid && (req_addr[28:2] == tag) && !inval;
    assign aligned = {req_addr[28:2], 2'b00};
`else
    localparam logic [7:0] BURST = 8'd1;
    localparam int unused_line_words = LINE_WORDS;

    logic unused_inval;

    assign unused_inval = inval;
    assign hit          = 1'b0;
    assign aligned      = req_addr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            req_dout       <= '0;
            req_busy       <= 1'b0;
            req_valid      <= 1'b0;
            DDRAM_RD       <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= 8'd1;
`ifdef PGM_GFX_CACHE_EN
            tag_valid      <= 1'b0;
            fill_kill      <= 1'b0;
            beat           <= '0;
`endif
        end else begin
            req_valid <= 1'b0;
`ifdef PGM_GFX_CACHE_EN
            if (inval) tag_valid <= 1'b0;
`endif
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (req_rd) begin
`ifdef PGM_GFX_CACHE_EN
                        addr_q <= req_addr;
`endif
                        req_busy <= 1'b1;
                        if (hit) begin
                            state <= HIT;
                        end else begin
                            state          <= ISSUE;
                            DDRAM_RD       <= 1'b1;
                            DDRAM_ADDR     <= BASE_ADDR + aligned;
                            DDRAM_BURSTCNT <= BURST;
                        end
                    end
                end
                HIT: begin
`ifdef PGM_GFX_CACHE_EN
                    req_dout <= line[addr_q[1:0]];
`endif
                    req_valid <= 1'b1;
                    req_busy  <= 1'b0;
                    state     <= DONE;
                end
                ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= WAIT;
`ifdef PGM_GFX_CACHE_EN
                        beat      <= '0;
                        fill_kill <= 1'b0;
`endif
                    end
                end
                WAIT: begin
`ifdef PGM_GFX_CACHE_EN
                    if (inval) fill_kill <= 1'b1;
                    if (DDRAM_DOUT_READY) begin
                        line[beat] <= DDRAM_DOUT;
                        beat       <= beat + 2'd1;
                        if (beat == 2'(LINE_WORDS - 1)) begin
                            // requested word may be the beat arriving now
                            req_dout  <= (beat == addr_q[1:0]) ?
                                         DDRAM_DOUT : line[addr_q[1:0]];
                            tag       <= addr_q[28:2];
                            tag_valid <= !(inval || fill_kill);
                            req_valid <= 1'b1;
                            req_busy  <= 1'b0;
                            state     <= DONE;
                        end
                    end
`else
                    if (DDRAM_DOUT_READY) begin
                        req_dout  <= DDRAM_DOUT;
                        req_valid <= 1'b1;
                        req_busy  <= 1'b0;
                        state     <= DONE;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pgm_gfx_ddr_bridge.sv
// Scoreboard bench for pgm_gfx_ddr_bridge; a second instance at a
// wrapping base address shares all inputs.
module tb_pgm_gfx_ddr_bridge;

    localparam logic [28:0] BASE  = 29'h0300_0000;
    localparam logic [28:0] WBASE = 29'h1FFF_FFFE;
`ifdef PGM_GFX_CACHE_EN
    localparam bit         CACHE_ON = 1'b1;
    localparam logic [7:0] BURST    = 8'd4;
`else
    localparam bit         CACHE_ON = 1'b0;
    localparam logic [7:0] BURST    = 8'd1;
`endif

    typedef struct {
        logic [28:0] addr;
        logic [28:0] waddr;
        logic [7:0]  burst;
    } cmd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_rd = 1'b0;
    logic [28:0] req_addr = '0;
    logic        inval = 1'b0;
    logic        ddr_busy = 1'b0;
    logic [63:0] ddr_dout = '0;
    logic        ddr_ready = 1'b0;

    logic [63:0] req_dout, w_req_dout;
    logic        req_busy, w_req_busy;
    logic        req_valid, w_req_valid;
    logic [28:0] ddr_addr, w_ddr_addr;
    logic [7:0]  ddr_burst, w_ddr_burst;
    logic        ddr_rd, w_ddr_rd;

    pgm_gfx_ddr_bridge #(.BASE_ADDR(BASE), .LINE_WORDS(4)) dut (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_addr(req_addr),
        .req_dout(req_dout), .req_busy(req_busy), .req_valid(req_valid),
        .inval(inval), .DDRAM_ADDR(ddr_addr), .DDRAM_BURSTCNT(ddr_burst),
        .DDRAM_RD(ddr_rd), .DDRAM_BUSY(ddr_busy), .DDRAM_DOUT(ddr_dout),
        .DDRAM_DOUT_READY(ddr_ready)
    );

    pgm_gfx_ddr_bridge #(.BASE_ADDR(WBASE), .LINE_WORDS(4)) dut_w (
        .clk(clk), .reset(reset), .req_rd(req_rd), .req_addr(req_addr),
        .req_dout(w_req_dout), .req_busy(w_req_busy), .req_valid(w_req_valid),
        .inval(inval), .DDRAM_ADDR(w_ddr_addr), .DDRAM_BURSTCNT(w_ddr_burst),
        .DDRAM_RD(w_ddr_rd), .DDRAM_BUSY(ddr_busy), .DDRAM_DOUT(ddr_dout),
        .DDRAM_DOUT_READY(ddr_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_valid = 0;
    int last_valid_cyc = 0;

    logic [63:0] exp_data[$];
    cmd_t        exp_cmd[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] dat(input logic [28:0] w);
        return 64'hD00D_0000_0000_0000 | {35'd0, w};
    endfunction

    // Monitor: every req_valid pulse pops one expected word
    always @(negedge clk) begin
        if (!reset && req_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            chk("busy_at_valid", {63'd0, req_busy}, 64'd0);
            chk("w_valid", {63'd0, w_req_valid}, 64'd1);
            if (exp_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got %h expected none",
                         req_dout);
            end else begin
                logic [63:0] e;
                e = exp_data.pop_front();
                chk("req_dout", req_dout, e);
                chk("w_req_dout", w_req_dout, e);
            end
        end
    end

    // DDR model and command monitor, driven on the falling edge
    int          stall_req = 0;
    int          stall_left = 0;
    int          beats_left = 0;
    int          dly = 0;
    int          beats_sent = 0;
    int          accepts = 0;
    bit          stray = 1'b0;
    bit          cmd_seen = 1'b0;
    logic [28:0] beat_addr = '0;
    logic [28:0] cmd_addr = '0;
    logic [7:0]  cmd_burst = '0;
    cmd_t        mc;

    always @(negedge clk) begin
        if (reset) begin
            ddr_busy   = 1'b0;
            ddr_ready  = 1'b0;
            beats_left = 0;
            stall_left = 0;
            cmd_seen   = 1'b0;
        end else begin
            ddr_ready = 1'b0;
            if (beats_left > 0) begin
                if (dly > 0) begin
                    dly--;
                end else begin
                    ddr_ready = 1'b1;
                    ddr_dout  = dat(beat_addr);
                    beat_addr = beat_addr + 29'd1;
                    beats_left--;
                    beats_sent++;
                end
            end else if (stray) begin
                ddr_ready = 1'b1;
                ddr_dout  = 64'hBAD0_BAD0_BAD0_BAD0;
                stray     = 1'b0;
            end
            if (ddr_rd) begin
                if (!cmd_seen) begin
                    cmd_seen   = 1'b1;
                    stall_left = stall_req;
                    stall_req  = 0;
                    cmd_addr   = ddr_addr;
                    cmd_burst  = ddr_burst;
                end else begin
                    chk("addr_stable", {35'd0, ddr_addr}, {35'd0, cmd_addr});
                    chk("burst_stable", {56'd0, ddr_burst}, {56'd0, cmd_burst});
                    chk("rd_stable", {63'd0, w_ddr_rd}, 64'd1);
                end
                if (stall_left > 0) begin
                    ddr_busy = 1'b1;
                    stall_left--;
                end else begin
                    ddr_busy = 1'b0;
                    cmd_seen = 1'b0;
                    accepts++;
                    chk("w_rd", {63'd0, w_ddr_rd}, 64'd1);
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got %h expected none",
                                 ddr_addr);
                    end else begin
                        mc = exp_cmd.pop_front();
                        chk("ddr_addr", {35'd0, ddr_addr}, {35'd0, mc.addr});
                        chk("w_ddr_addr", {35'd0, w_ddr_addr},
                            {35'd0, mc.waddr});
                        chk("ddr_burst", {56'd0, ddr_burst}, {56'd0, mc.burst});
                        chk("w_ddr_burst", {56'd0, w_ddr_burst},
                            {56'd0, mc.burst});
                    end
                    beats_left = int'(ddr_burst);
                    beat_addr  = ddr_addr;
                    dly        = 2;
                end
            end else begin
                ddr_busy = 1'b0;
            end
        end
    end

    function automatic logic [28:0] align(input logic [28:0] a);
        return CACHE_ON ? {a[28:2], 2'b00} : a;
    endfunction

    task automatic push_cmd(input logic [28:0] a);
        cmd_t c;
        c.addr  = BASE + align(a);
        c.waddr = WBASE + align(a);
        c.burst = BURST;
        exp_cmd.push_back(c);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dout"}, req_dout, 64'd0);
        chk({tag, "_busy"}, {63'd0, req_busy}, 64'd0);
        chk({tag, "_valid"}, {63'd0, req_valid}, 64'd0);
        chk({tag, "_rd"}, {63'd0, ddr_rd}, 64'd0);
        chk({tag, "_addr"}, {35'd0, ddr_addr}, 64'd0);
        chk({tag, "_waddr"}, {35'd0, w_ddr_addr}, 64'd0);
        chk({tag, "_burst"}, {56'd0, ddr_burst}, 64'd1);
    endtask

    task automatic wait_valid(input int target, input string name);
        int n;
        n = 0;
        while (n_valid < target && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        if (n_valid < target) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d valids expected %0d",
                     name, n_valid, target);
        end
    endtask

    // One request; hit is what a cache-on build would do
    task automatic issue(input logic [28:0] a, input bit hit, input bit iv,
                         input int stall, input bit inval_mid);
        bit is_hit;
        int t0;
        int nv;
        int exp_lat;
        int n;
        n = 0;
        while (req_busy && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        is_hit    = CACHE_ON && hit;
        stall_req = stall;
        req_rd    = 1'b1;
        req_addr  = a;
        inval     = iv;
        exp_data.push_back(dat(BASE + a));
        if (!is_hit) push_cmd(a);
        t0 = cyc;
        nv = n_valid;
        @(posedge clk) #1;
        req_rd = 1'b0;
        inval  = 1'b0;
        if (inval_mid) begin
            @(posedge clk) #1;
            inval = 1'b1;
            @(posedge clk) #1;
            inval = 1'b0;
        end
        wait_valid(nv + 1, "req");
        exp_lat = is_hit ? 2 : 2 + stall + 2 + int'(BURST);
        chk("latency", 64'(last_valid_cyc - t0), 64'(exp_lat));
    endtask

    initial begin
        int nv;
        int b0;
        int a0;
        int n;
        int exp_n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("rst");
        @(posedge clk) #1;
        reset = 1'b0;
        @(posedge clk) #1;

        issue(29'h5, 1'b0, 1'b0, 0, 1'b0);
        issue(29'h7, 1'b1, 1'b0, 0, 1'b0);
        issue(29'h3, 1'b0, 1'b0, 0, 1'b0);
        issue(29'h10, 1'b0, 1'b0, 5, 1'b0);
        issue(29'h12, 1'b1, 1'b0, 0, 1'b0);
        issue(29'h5, 1'b0, 1'b0, 0, 1'b0);
        issue(29'h6, 1'b0, 1'b1, 0, 1'b0);
        issue(29'h7, 1'b1, 1'b0, 0, 1'b0);
        issue(29'h21, 1'b0, 1'b0, 0, 1'b1);
        issue(29'h22, 1'b0, 1'b0, 0, 1'b0);

        stray = 1'b1;
        repeat (3) @(posedge clk) #1;
        issue(29'h23, 1'b1, 1'b0, 0, 1'b0);

        // held request: accepted again in DONE when hitting
        nv       = n_valid;
        exp_n    = CACHE_ON ? 2 : 1;
        req_rd   = 1'b1;
        req_addr = 29'h20;
        for (int i = 0; i < exp_n; i++) exp_data.push_back(dat(BASE + 29'h20));
        if (!CACHE_ON) push_cmd(29'h20);
        repeat (3) @(posedge clk) #1;
        req_rd = 1'b0;
        wait_valid(nv + exp_n, "b2b");
        repeat (3) @(posedge clk) #1;
        chk("b2b_count", 64'(n_valid - nv), 64'(exp_n));

        // reset in the middle of a burst
        b0       = beats_sent;
        a0       = accepts;
        req_rd   = 1'b1;
        req_addr = 29'h31;
        push_cmd(29'h31);
        @(posedge clk) #1;
        req_rd = 1'b0;
        n = 0;
        while ((accepts < a0 + 1 ||
                beats_sent < b0 + (CACHE_ON ? 2 : 0)) && n < 200) begin
            @(posedge clk) #1;
            n++;
        end
        chk("midburst_reached", {63'd0, (n < 200)}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("midrst");
        @(posedge clk) #1;
        reset = 1'b0;
        @(posedge clk) #1;
        issue(29'h5, 1'b0, 1'b0, 0, 1'b0);

        repeat (10) @(posedge clk) #1;
        chk("pending_data", 64'(exp_data.size()), 64'd0);
        chk("pending_cmd", 64'(exp_cmd.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
